// File: rtl/codec_rx.sv
// codec_rx: masters the audio codec clocks (MCLK/SCLK/LRCLK) from a free-running
// 10-bit frame counter and deserializes I2S data from the codec into 16-bit
// signed left/right samples.
//
// Output handshake: vld is a one-cycle strobe with no ready/backpressure. When vld
// is high, lft_chnnl and rght_chnnl hold a coherent pair from the same frame.
// rght_chnnl holds for a full frame, and lft_chnnl holds for 512 cycles after vld.
// Consumers must capture on vld.
module codec_rx (
    input  logic        clk,
    input  logic        rst_n,
    output logic        MCLK,
    output logic        SCLK,
    output logic        LRCLK,
    output logic        RSTn,
    input  logic        SDout,
    output logic [15:0] lft_chnnl,
    output logic [15:0] rght_chnnl,
    output logic        vld
);

    // HOLD keeps the codec in reset for one frame. SYNC lets it settle for one frame.
    // RUN accepts captures.
    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_SYNC = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    // Counter values at which the left/right words complete. Each value is the
    // sample point of the word's LSB slot.
    localparam logic [9:0] CNT_LFT_DONE  = 10'd528;
    localparam logic [9:0] CNT_RGHT_DONE = 10'd16;
    localparam logic [9:0] CNT_LAST      = 10'd1023;

    state_t      state_q, state_d;
    logic [9:0]  cnt_q, cnt_d;
    logic        rstn_q, rstn_d;
    logic        primed_q, primed_d;
    logic [15:0] sh_q, sh_d;
    logic [15:0] lft_q, lft_d;
    logic [15:0] rght_q, rght_d;
    logic        vld_q, vld_d;

    logic        sample_pt;
    logic        frame_end;
    logic [15:0] word_in;

    // The sample point is the first clk with SCLK high, which is mid bit-period.
    assign sample_pt = (cnt_q[4:0] == 5'd16);
    assign frame_end = (cnt_q == CNT_LAST);
    assign word_in   = {sh_q[14:0], SDout};

    // Next-state logic for the counter, the shifter, the sequencer and the capture registers.
    always_comb begin
        cnt_d    = cnt_q + 10'd1;
        state_d  = state_q;
        rstn_d   = rstn_q;
        primed_d = primed_q;
        sh_d     = sh_q;
        lft_d    = lft_q;
        rght_d   = rght_q;
        vld_d    = 1'b0;

        if (sample_pt) begin
            sh_d = word_in;
        end

        case (state_q)
            ST_HOLD: begin
                rstn_d = 1'b0;
                if (frame_end) begin
                    state_d = ST_SYNC;
                    rstn_d  = 1'b1;
                end
            end
            ST_SYNC: begin
                rstn_d = 1'b1;
                if (frame_end) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                rstn_d = 1'b1;
                if (cnt_q == CNT_LFT_DONE) begin
                    lft_d    = word_in;
                    primed_d = 1'b1;
                end
                // The first RUN right word has no matching left word, so it raises no vld.
                if (cnt_q == CNT_RGHT_DONE) begin
                    rght_d = word_in;
                    vld_d  = primed_q;
                end
            end
            default: begin
                state_d = ST_HOLD;
                rstn_d  = 1'b0;
            end
        endcase
    end

    // State register with synchronous active-low reset. All outputs are registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_HOLD;
            cnt_q    <= 10'd0;
            rstn_q   <= 1'b0;
            primed_q <= 1'b0;
            sh_q     <= 16'd0;
            lft_q    <= 16'd0;
            rght_q   <= 16'd0;
            vld_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rstn_q   <= rstn_d;
            primed_q <= primed_d;
            sh_q     <= sh_d;
            lft_q    <= lft_d;
            rght_q   <= rght_d;
            vld_q    <= vld_d;
        end
    end

    // The codec clocks are raw counter bits, so they cannot glitch.
    assign MCLK       = cnt_q[1];
    assign SCLK       = cnt_q[4];
    assign LRCLK      = cnt_q[9];
    assign RSTn       = rstn_q;
    assign lft_chnnl  = lft_q;
    assign rght_chnnl = rght_q;
    assign vld        = vld_q;

endmodule

// File: tb/tb_codec_rx.sv
// tb_codec_rx: the codec model streams I2S frames from a vector table. The bench
// keeps its own frame counter and checks the clocks, the codec reset, the capture
// edges and the vld pairs.
module tb_codec_rx;

    logic        clk;
    logic        rst_n;
    logic        MCLK;
    logic        SCLK;
    logic        LRCLK;
    logic        RSTn;
    logic        SDout;
    logic [15:0] lft_chnnl;
    logic [15:0] rght_chnnl;
    logic        vld;

    codec_rx dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .MCLK       (MCLK),
        .SCLK       (SCLK),
        .LRCLK      (LRCLK),
        .RSTn       (RSTn),
        .SDout      (SDout),
        .lft_chnnl  (lft_chnnl),
        .rght_chnnl (rght_chnnl),
        .vld        (vld)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #10 clk = ~clk;

    // ---------------- vector table ----------------
    typedef struct {
        logic [15:0] l_in;
        logic [15:0] r_in;
        logic [15:0] l_exp;
        logic [15:0] r_exp;
    } vec_t;

    localparam int NV = 5;
    vec_t tbl[NV];

    // ---------------- bench state / scoreboard ----------------
    logic [31:0] exp_q[$];
    int          n_checks;
    int          n_fail;
    int          n;          // edges since reset release
    logic [9:0]  tb_cnt;     // bench's own frame counter
    logic [15:0] frame_l, frame_r, prev_l, prev_r;
    logic        prev_r0;
    int          vld_seen;
    int          rstn_low;
    int          first_vld;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (n=%0d)", name, act, exp, n);
        end
    endtask

    // Codec model: the bit on SDout for the current slot.
    function automatic logic sd_bit();
        int s;
        s = int'(tb_cnt[9:5]);
        if (s == 0)
            return prev_r0;
        else if (s <= 16)
            return frame_l[16 - s];
        else
            return frame_r[32 - s];
    endfunction

    // Frame start: roll the model to the next table entry, and queue the pair
    // that the DUT must report one frame later.
    task automatic load_frame();
        int k;
        int idx;
        k = n / 1024;
        prev_l  = frame_l;
        prev_r  = frame_r;
        prev_r0 = frame_r[0];
        idx = (k >= 2) ? k - 2 : 0;
        if (idx > NV - 1) idx = NV - 1;
        frame_l = tbl[idx].l_in;
        frame_r = tbl[idx].r_in;
        if (k >= 2 && k - 2 < NV)
            exp_q.push_back({tbl[k - 2].l_exp, tbl[k - 2].r_exp});
    endtask

    // One clk: apply the edge, advance the model, drive SDout, run the per-cycle checks.
    task automatic step();
        logic r;
        int   pre;
        logic exp_vld;
        r   = rst_n;
        pre = int'(tb_cnt);
        @(posedge clk);
        #1;
        if (!r) begin
            n       = 0;
            tb_cnt  = 10'd0;
            prev_r0 = 1'b0;
            prev_l  = 16'd0;
            prev_r  = 16'd0;
            frame_l = tbl[0].l_in;
            frame_r = tbl[0].r_in;
            exp_q.delete();
        end else begin
            n++;
            tb_cnt = 10'(n % 1024);
            if (tb_cnt == 10'd0) load_frame();
        end
        SDout = sd_bit();

        check("clocks_rstn", {28'd0, MCLK, SCLK, LRCLK, RSTn},
              {28'd0, tb_cnt[1], tb_cnt[4], tb_cnt[9], (n >= 1024)});
        exp_vld = (n >= 3089) && (((n - 3089) % 1024) == 0);
        check("vld", {31'd0, vld}, {31'd0, exp_vld});
        if (vld) vld_seen++;
        if (!r) check("reset_samples", {lft_chnnl, rght_chnnl}, 32'd0);
        if (exp_vld) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL vld_pair: got %h expected no pending pair", {lft_chnnl, rght_chnnl});
            end else begin
                check("vld_pair", {lft_chnnl, rght_chnnl}, exp_q.pop_front());
            end
        end
        if (r && pre == 528 && n >= 2577) check("lft_capture", {16'd0, lft_chnnl}, {16'd0, frame_l});
        if (r && pre == 16 && n >= 2065) check("rght_capture", {16'd0, rght_chnnl}, {16'd0, prev_r});
    endtask

    // ---------------- test sequence ----------------
    initial begin
        tbl[0] = '{16'h1234, 16'hA5C3, 16'h1234, 16'hA5C3};
        tbl[1] = '{16'h1234, 16'hA5C3, 16'h1234, 16'hA5C3};
        tbl[2] = '{16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF};
        tbl[3] = '{16'hFFFF, 16'h0001, 16'hFFFF, 16'h0001};
        tbl[4] = '{16'h0F0F, 16'h0001, 16'h0F0F, 16'h0001};

        n_checks = 0;
        n_fail   = 0;
        n        = 0;
        tb_cnt   = 10'd0;
        frame_l  = tbl[0].l_in;
        frame_r  = tbl[0].r_in;
        prev_l   = 16'd0;
        prev_r   = 16'd0;
        prev_r0  = 1'b0;
        vld_seen = 0;
        rst_n    = 1'b0;
        SDout    = 1'b0;

        // Reset values
        repeat (5) step();
        check("rst_lft",   {16'd0, lft_chnnl}, 32'd0);
        check("rst_rght",  {16'd0, rght_chnnl}, 32'd0);
        check("rst_vld",   {31'd0, vld}, 32'd0);
        check("rst_mclk",  {31'd0, MCLK}, 32'd0);
        check("rst_sclk",  {31'd0, SCLK}, 32'd0);
        check("rst_lrclk", {31'd0, LRCLK}, 32'd0);
        check("rst_rstn",  {31'd0, RSTn}, 32'd0);

        // Release, then stream the vector table through the codec model
        rst_n    = 1'b1;
        rstn_low = (RSTn == 1'b0) ? 1 : 0;
        vld_seen = 0;
        for (int i = 0; i < 7200; i++) begin
            step();
            if (RSTn == 1'b0) rstn_low++;
            if (n == 6672) check("bnd_lft_before", {16'd0, lft_chnnl}, {16'd0, 16'hFFFF});
            if (n == 6673) check("bnd_lft_after",  {16'd0, lft_chnnl}, {16'd0, 16'h0F0F});
            if (n == 7185) check("bnd_pair", {lft_chnnl, rght_chnnl}, {16'h0F0F, 16'h0001});
        end
        check("rstn_low_cycles", rstn_low, 1024);
        check("vld_count_run1", vld_seen, NV);
        check("queue_drained", exp_q.size(), 0);

        // Reset mid-frame at cnt==300 in RUN
        begin
            int guard;
            guard = 0;
            while (tb_cnt != 10'd300 && guard < 1100) begin
                step();
                guard++;
            end
            check("reach_cnt300", {22'd0, tb_cnt}, 32'd300);
        end
        rst_n = 1'b0;
        step();
        check("midrst_rstn", {31'd0, RSTn}, 32'd0);
        check("midrst_vld",  {31'd0, vld}, 32'd0);
        check("midrst_lft",  {16'd0, lft_chnnl}, 32'd0);
        check("midrst_rght", {16'd0, rght_chnnl}, 32'd0);
        check("midrst_clks", {29'd0, MCLK, SCLK, LRCLK}, 32'd0);
        step();
        step();
        rst_n     = 1'b1;
        vld_seen  = 0;
        first_vld = -1;
        for (int i = 0; i < 3200; i++) begin
            step();
            if (vld && first_vld < 0) first_vld = n;
        end
        check("vld_count_run2", vld_seen, 1);
        check("first_vld_edge", first_vld, 3089);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/codec_rx.md
# codec_rx

Serial audio front end that masters the codec clocks and deserializes the codec's I2S data output into 16-bit signed left/right samples with a one-cycle `vld` strobe. It sits between the external audio codec pins and every downstream sample consumer, including the LED intensity driver and the filter chain. It drives `lft_chnnl`, `rght_chnnl` and `vld` with exactly the semantics those consumers expect.

## Interface
- None: the frame geometry is fixed by the codec board and is not parameterized.

- `clk`  input  1  system clock, 50 MHz
- `rst_n`  input  1  reset, synchronous, active-low
- `MCLK`  output  1  codec master clock, clk/4
- `SCLK`  output  1  serial bit clock, clk/32
- `LRCLK`  output  1  frame clock, clk/1024; low = left half, high = right half
- `RSTn`  output  1  codec reset, active-low
- `SDout`  input  1  serial data from codec, MSB first, I2S one-bit delay
- `lft_chnnl`  output  16  signed left sample
- `rght_chnnl`  output  16  signed right sample
- `vld`  output  1  one-cycle pulse: new left/right pair is valid

## Operation
- 10-bit free-running counter `cnt` increments every clk and wraps 1023→0.
- Clock outputs are direct counter bits, so they are glitch-free:
  - `MCLK` = `cnt[1]`
  - `SCLK` = `cnt[4]`
  - `LRCLK` = `cnt[9]`
- Bit slot `s` = `cnt[9:5]` (0..31).
- Sample point: the clk edge at which `cnt[4:0]==16`, i.e. the first clk with `SCLK` high. On every sample point, `SDout` shifts into a 16-bit register: `sh <= {sh[14:0], SDout}`.
- I2S slot mapping:
  - Left MSB is in slot 1; left bits 15..1 occupy slots 1..15; left LSB is in slot 16.
  - Right MSB is in slot 17; right LSB is in slot 0 of the next frame.
- Left capture: at the sample point with `cnt==528`, `lft_chnnl <= {sh[14:0], SDout}`.
- Right capture: at the sample point with `cnt==16`, `rght_chnnl <= {sh[14:0], SDout}`. In the same edge, `vld <= 1` if `primed`; otherwise `vld <= 0`.
- `vld` is otherwise 0 and is never high for two consecutive cycles.
- State machine, with `cnt` running in all states:
  - HOLD: `RSTn=0`. At the edge where `cnt==1023`, go to SYNC.
  - SYNC: `RSTn=1`; codec settling, all captures ignored. At the edge where `cnt==1023`, go to RUN.
  - RUN: `RSTn=1`; captures active. `primed` is set at the first RUN left capture (`cnt==528`).
- The right capture at `cnt==16` in the first RUN frame completes no valid pair. It updates `rght_chnnl` but does not pulse `vld`.
- No exit from RUN except reset.
- Sample values are raw two's complement. No sign manipulation, scaling or averaging.

## Timing
- Reset (`rst_n` low at a clk edge) sets:
  - `cnt=0`, state=HOLD, `primed=0`, `sh=0`
  - `lft_chnnl=0`, `rght_chnnl=0`, `vld=0`
  - `MCLK=SCLK=LRCLK=0`, `RSTn=0`
- Reset mid-operation (any state, any `cnt`): same result at that edge. The full HOLD→SYNC→RUN sequence restarts.
- Edge numbering: n=1 is the first edge with `rst_n` high, and `cnt` equals n mod 1024 after edge n.
- Sequence after reset release:
  - `RSTn` rises after edge 1024.
  - RUN starts after edge 2048.
  - First left capture at edge 2048+529.
  - First `vld` high in the cycle after edge 3072+17, then every 1024 cycles.
- Data coherence:
  - When `vld` is high, `lft_chnnl` and `rght_chnnl` belong to the same frame.
  - `rght_chnnl` is stable for 1024 cycles.
  - `lft_chnnl` is stable for 512 cycles after the `vld` edge.
- Consumers must sample on `vld`.
- Latency from the right LSB on `SDout` at the sample point to `vld`/`rght_chnnl` visible: 1 clk.

## Test plan
- Reset values: hold `rst_n` low 5 cycles → all outputs 0, `RSTn=0`. Release → `MCLK` period 4, `SCLK` period 32, `LRCLK` period 1024 with 512 low first.
- Codec reset: count cycles with `RSTn=0` after release → exactly 1024, then `RSTn` stays 1.
- I2S codec model sends left=16'h1234, right=16'hA5C3 every frame → first `vld` after edge 3089, at which `lft_chnnl=16'h1234` and `rght_chnnl=16'hA5C3`. Subsequent `vld` pulses every 1024 cycles, each exactly 1 cycle wide.
- Extremes: left=16'h8000, right=16'h7FFF, then left=16'hFFFF, right=16'h0001 on consecutive frames → each captured bit-exact on its own `vld`.
- Frame boundary: change the model's left to 16'h0F0F mid-stream → `lft_chnnl` updates at the `cnt==528` edge; `rght_chnnl`/`vld` follow at the next `cnt==16` edge.
- Reset mid-frame: assert `rst_n` low at `cnt==300` in RUN → outputs zero on that edge, `RSTn=0`, and no `vld` until 3089 edges after re-release.
